// File: rtl/univ_counter_checker.sv
// Self-checking monitor for a universal mod-M up/down counter. A reference model runs
// in lockstep with the counter under test and flags any divergence in q or its tick flags.
module univ_counter_checker #(
  parameter int N           = 4,
  parameter int M           = 10,
  parameter int ERR_W       = 8,
  parameter int RESYNC      = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic             max_tick,
  input  logic             min_tick,
  input  logic [N-1:0]     q,
  output logic             err,
  output logic [2:0]       err_vec,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] chk_cnt,
  output logic             fail,
  output logic [N-1:0]     first_q,
  output logic [N-1:0]     first_gold,
  output logic [1:0]       state
);

  // state | meaning
  // IDLE  | first edge after reset: seed model from q, no compare
  // TRACK | compare every edge, step model
  // HALT  | frozen after first error (STOP_ON_ERR only)
  typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, HALT = 2'b10} state_t;

  localparam logic [N-1:0] TOP = N'(M - 1);
  // One extra bit so M = 2**N is representable and range_err can never fire.
  localparam logic [N:0]   MOD = (N + 1)'(M);

  state_t       cur, nxt;
  logic [N-1:0] gold, gold_next;
  logic         q_err, tick_err, range_err;
  logic [2:0]   vec_now;
  logic         hit;

  function automatic logic [N-1:0] step(input logic [N-1:0] x, input logic c, input logic l,
                                        input logic e, input logic u, input logic [N-1:0] dv);
    logic [N-1:0] r;
    if (c)           r = '0;
    else if (l)      r = dv;
    else if (e && u) r = (x >= TOP) ? '0 : x + 1'b1;
    else if (e)      r = (x == '0) ? TOP : x - 1'b1;
    else             r = x;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = TRACK;
      TRACK:   if (hit && (STOP_ON_ERR != 0)) nxt = HALT;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    q_err     = (q != gold);
    tick_err  = (max_tick != (q == TOP)) || (min_tick != (q == '0));
    range_err = ({1'b0, q} >= MOD);
    vec_now   = (cur == TRACK) ? {tick_err, range_err, q_err} : 3'b000;
    hit       = |vec_now;
    gold_next = gold;
    case (cur)
      IDLE:    gold_next = step(q, syn_clr, load, en, up, d);
      TRACK:   gold_next = (hit && (RESYNC != 0)) ? step(q, syn_clr, load, en, up, d)
                                                  : step(gold, syn_clr, load, en, up, d);
      default: gold_next = gold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gold       <= '0;
      err        <= 1'b0;
      err_vec    <= 3'b000;
      err_cnt    <= '0;
      chk_cnt    <= '0;
      fail       <= 1'b0;
      first_q    <= '0;
      first_gold <= '0;
    end else begin
      gold    <= gold_next;
      err     <= hit;
      err_vec <= vec_now;
      if (cur == TRACK && chk_cnt != '1) chk_cnt <= chk_cnt + 1'b1;
      if (hit && err_cnt != '1)          err_cnt <= err_cnt + 1'b1;
      if (hit && !fail) begin
        fail       <= 1'b1;
        first_q    <= q;
        first_gold <= gold;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_univ_counter_checker.sv
// Directed bench: a behavioural mod-10 counter with fault hooks drives four checker
// instances (default, no-resync, stop-on-error, 2-bit saturating no-resync).
module tb_univ_counter_checker;

  logic       clk = 1'b0;
  logic       reset, syn_clr, load, en, up;
  logic [3:0] d;
  logic [3:0] cq;
  logic       max_tick, min_tick;
  logic       stall, bug_prio, max_ov;

  logic       err_a, err_b, err_c, err_s;
  logic [2:0] vec_a, vec_b, vec_c, vec_s;
  logic [7:0] ecnt_a, ccnt_a, ecnt_b, ccnt_b, ecnt_c, ccnt_c;
  logic [1:0] ecnt_s, ccnt_s;
  logic       fail_a, fail_b, fail_c, fail_s;
  logic [3:0] fq_a, fg_a, fq_b, fg_b, fq_c, fg_c, fq_s, fg_s;
  logic [1:0] st_a, st_b, st_c, st_s;

  int n_chk = 0;
  int n_fail = 0;
  int errs_a, errs_b;

  always #5 clk = ~clk;

  function automatic logic [3:0] tf(input logic [3:0] x);
    if (syn_clr) return 4'd0;
    if (load)    return d;
    if (en && up) return (x >= 4'd9) ? 4'd0 : 4'(x + 1);
    if (en)      return (x == 4'd0) ? 4'd9 : 4'(x - 1);
    return x;
  endfunction

  // Counter under test with injectable faults.
  always @(posedge clk) begin
    if (!reset)               cq <= 4'd0;
    else if (stall)           cq <= cq;
    else if (bug_prio && load) cq <= d;
    else                      cq <= tf(cq);
  end
  assign max_tick = max_ov | (cq == 4'd9);
  assign min_tick = (cq == 4'd0);

  univ_counter_checker u_def (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
    .max_tick(max_tick), .min_tick(min_tick), .q(cq),
    .err(err_a), .err_vec(vec_a), .err_cnt(ecnt_a), .chk_cnt(ccnt_a), .fail(fail_a),
    .first_q(fq_a), .first_gold(fg_a), .state(st_a));

  univ_counter_checker #(.RESYNC(0)) u_nores (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
    .max_tick(max_tick), .min_tick(min_tick), .q(cq),
    .err(err_b), .err_vec(vec_b), .err_cnt(ecnt_b), .chk_cnt(ccnt_b), .fail(fail_b),
    .first_q(fq_b), .first_gold(fg_b), .state(st_b));

  univ_counter_checker #(.STOP_ON_ERR(1)) u_stop (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
    .max_tick(max_tick), .min_tick(min_tick), .q(cq),
    .err(err_c), .err_vec(vec_c), .err_cnt(ecnt_c), .chk_cnt(ccnt_c), .fail(fail_c),
    .first_q(fq_c), .first_gold(fg_c), .state(st_c));

  univ_counter_checker #(.ERR_W(2), .RESYNC(0)) u_sat (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
    .max_tick(max_tick), .min_tick(min_tick), .q(cq),
    .err(err_s), .err_vec(vec_s), .err_cnt(ecnt_s), .chk_cnt(ccnt_s), .fail(fail_s),
    .first_q(fq_s), .first_gold(fg_s), .state(st_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    syn_clr = 0; load = 0; en = 0; up = 0; d = 0;
    stall = 0; bug_prio = 0; max_ov = 0;
  endtask

  task automatic do_reset();
    idle_ctl();
    reset = 0;
    cyc(2);
    reset = 1;
  endtask

  initial begin
    idle_ctl();
    reset = 0;
    cyc(2);
    check("rst_err_cnt", ecnt_a, 0);
    check("rst_chk_cnt", ccnt_a, 0);
    check("rst_state", st_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_err", err_a, 0);

    // 1: clean up-count, 25 edges, two wraps
    do_reset();
    en = 1; up = 1;
    errs_a = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      errs_a += int'(err_a);
    end
    check("s1_err_pulses", errs_a, 0);
    check("s1_chk_cnt", ccnt_a, 24);
    check("s1_fail", fail_a, 0);
    check("s1_state", st_a, 1);
    check("s1_sat_chk_cnt", ccnt_s, 3);

    // 2: down-count from 0 through 9 and back through 0
    do_reset();
    en = 1; up = 0;
    cyc(1);
    check("s2_idle_no_chk", ccnt_a, 0);
    check("s2_state_track", st_a, 1);
    errs_a = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      errs_a += int'(err_a);
    end
    check("s2_err_pulses", errs_a, 0);
    check("s2_chk_cnt", ccnt_a, 12);

    // load d>=M: flagged by range_err, next up step wraps to 0
    do_reset();
    load = 1; d = 4'd12;
    cyc(1);
    load = 0; en = 1; up = 1;
    cyc(1);
    check("ld_err", err_a, 1);
    check("ld_err_vec", vec_a, 3'b010);
    check("ld_first_q", fq_a, 12);
    check("ld_first_gold", fg_a, 12);
    cyc(1);
    check("ld_wrap_clean", err_a, 0);

    // 3: syn_clr+load together; counter wrongly honours load
    do_reset();
    cyc(1);
    syn_clr = 1; load = 1; d = 4'd7; bug_prio = 1;
    cyc(1);
    idle_ctl();
    cyc(1);
    check("s3_err", err_a, 1);
    check("s3_err_vec", vec_a, 3'b001);
    check("s3_first_q", fq_a, 7);
    check("s3_first_gold", fg_a, 0);
    check("s3_fail", fail_a, 1);
    check("s3_stop_state", st_c, 2);
    cyc(1);
    check("s3_resync_clean", err_a, 0);
    check("s3_err_cnt", ecnt_a, 1);
    check("s3_fail_sticky", fail_a, 1);
    check("s3_nores_err", err_b, 1);
    check("s3_nores_err_cnt", ecnt_b, 2);

    // 4: counter stalls at 3 for one edge
    do_reset();
    en = 1; up = 1;
    cyc(3);
    stall = 1;
    cyc(1);
    stall = 0;
    check("s4_pre_err", err_a, 0);
    cyc(1);
    check("s4_err", err_a, 1);
    check("s4_err_vec", vec_a, 3'b001);
    check("s4_err_cnt", ecnt_a, 1);
    check("s4_nores_err", err_b, 1);
    cyc(1);
    check("s4_post_clean", err_a, 0);
    errs_a = 0; errs_b = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      errs_a += int'(err_a);
      errs_b += int'(err_b);
    end
    check("s4_def_pulses", errs_a, 0);
    check("s4_def_err_cnt", ecnt_a, 1);
    check("s4_nores_pulses", errs_b, 6);
    check("s4_nores_err_cnt", ecnt_b, 8);
    check("s6_sat_err_cnt", ecnt_s, 3);
    check("s6_sat_fail", fail_s, 1);

    // 6: reset mid-run
    reset = 0;
    cyc(1);
    check("s6_rst_err_cnt", ecnt_s, 0);
    check("s6_rst_chk_cnt", ccnt_s, 0);
    check("s6_rst_fail", fail_s, 0);
    check("s6_rst_state", st_s, 0);
    reset = 1;
    cyc(1);
    check("s6_idle_state", st_s, 1);
    check("s6_idle_no_chk", ccnt_s, 0);
    check("s6_idle_no_err", err_s, 0);
    cyc(1);
    check("s6_first_chk", ccnt_s, 1);

    // 5: spurious max_tick at q=4 with STOP_ON_ERR
    do_reset();
    en = 1; up = 1;
    cyc(4);
    max_ov = 1;
    cyc(1);
    max_ov = 0;
    check("s5_err", err_c, 1);
    check("s5_err_vec", vec_c, 3'b100);
    check("s5_state", st_c, 2);
    check("s5_err_cnt", ecnt_c, 1);
    cyc(3);
    check("s5_halt_err", err_c, 0);
    check("s5_halt_vec", vec_c, 0);
    check("s5_halt_err_cnt", ecnt_c, 1);
    check("s5_halt_chk_cnt", ccnt_c, 4);
    check("s5_halt_state", st_c, 2);
    check("s5_first_q", fq_c, 4);
    check("s5_first_gold", fg_c, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
